// File: rtl/boolnet_pkg.sv
// Shared types for the Boolean-network simulation controller.
// FSM encoding, result classification and the cycle-length width helper.
package boolnet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_STEADY,
    RES_CYCLE,
    RES_TIMEOUT
  } result_t;

  // Width able to hold cycle lengths 0..depth.
  function automatic int cycle_len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/state_history.sv
// Past-state shift register with valid bits and a lowest-index match encoder.
// Compare is combinational against nxt; shifting happens one edge after load/shift.
module state_history
  import boolnet_pkg::*;
#(
  parameter int STATE_W    = 16,
  parameter int HIST_DEPTH = 4,
  localparam int IDX_W     = cycle_len_w(HIST_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [STATE_W-1:0] load_val,
  input  logic               shift,
  input  logic [STATE_W-1:0] nxt,
  output logic               match,
  output logic [IDX_W-1:0]   match_idx
);

  logic [STATE_W-1:0]    hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
      vld <= '0;
    end else if (load) begin
      hist[0] <= load_val;
      vld     <= HIST_DEPTH'(1);
    end else if (shift) begin
      hist[0] <= nxt;
      vld[0]  <= 1'b1;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hist[k] <= hist[k-1];
        vld[k]  <= vld[k-1];
      end
    end
  end

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int j = HIST_DEPTH - 1; j >= 0; j--) begin
      if (vld[j] && (hist[j] == nxt)) begin
        match     = 1'b1;
        match_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/boolnet_attractor_sim.sv
// Boolean-network run controller: masked load, req/valid iteration, attractor/timeout detection.
// One cycle per iteration with a combinational datapath; upd_req holds until upd_valid or abort.
module boolnet_attractor_sim
  import boolnet_pkg::*;
#(
  parameter int STATE_W    = 16,
  parameter int HIST_DEPTH = 4,
  parameter int ITER_W     = 10,
  localparam int SEL_W     = $clog2(STATE_W),
  localparam int CL_W      = cycle_len_w(HIST_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [STATE_W-1:0] initial_state,
  input  logic [ITER_W-1:0]  max_iter,
  input  logic               ld_inhibitor,
  input  logic [SEL_W-1:0]   sel_inhibitor,
  input  logic               clr_inhibitor,
  output logic               upd_req,
  output logic [STATE_W-1:0] upd_state,
  input  logic               upd_valid,
  input  logic [STATE_W-1:0] upd_next,
  output logic [STATE_W-1:0] network_state,
  output logic               busy,
  output logic               done,
  output logic               steady_state,
  output logic               cycle_detected,
  output logic               timeout,
  output logic [CL_W-1:0]    cycle_len,
  output logic [ITER_W-1:0]  iteration_number
);

  fsm_t               fsm;
  logic [STATE_W-1:0] mask;
  logic [ITER_W-1:0]  max_q;
  logic [STATE_W-1:0] nxt;
  logic [STATE_W-1:0] init_masked;
  logic [ITER_W-1:0]  cnt_next;
  logic               tmo;
  logic               match;
  logic [CL_W-1:0]    match_idx;
  logic               load;
  logic               accept;
  logic [SEL_W:0]     sel_ext;
  result_t            res;

  assign nxt         = upd_next & ~mask;
  assign init_masked = initial_state & ~mask;
  assign cnt_next    = iteration_number + ITER_W'(1);
  assign tmo         = (max_q != '0) ? (cnt_next == max_q) : (&cnt_next);
  assign load        = (fsm == IDLE) && start;
  assign accept      = (fsm == RUN) && !abort && upd_valid;
  assign sel_ext     = {1'b0, sel_inhibitor};
  assign upd_req     = busy;
  assign upd_state   = network_state;

  state_history #(
    .STATE_W   (STATE_W),
    .HIST_DEPTH(HIST_DEPTH)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (init_masked),
    .shift    (accept),
    .nxt      (nxt),
    .match    (match),
    .match_idx(match_idx)
  );

  always_comb begin
    res = RES_NONE;
    if (match)    res = (match_idx == '0) ? RES_STEADY : RES_CYCLE;
    else if (tmo) res = RES_TIMEOUT;
  end

  // Clear beats set; the mask is frozen for the whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (!busy) begin
      if (clr_inhibitor)
        mask <= '0;
      else if (ld_inhibitor && (sel_ext < (SEL_W+1)'(STATE_W)))
        mask[sel_inhibitor] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm              <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      max_q            <= '0;
      network_state    <= '0;
      iteration_number <= '0;
      steady_state     <= 1'b0;
      cycle_detected   <= 1'b0;
      timeout          <= 1'b0;
      cycle_len        <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            fsm              <= RUN;
            busy             <= 1'b1;
            network_state    <= init_masked;
            iteration_number <= '0;
            max_q            <= max_iter;
            steady_state     <= 1'b0;
            cycle_detected   <= 1'b0;
            timeout          <= 1'b0;
            cycle_len        <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            fsm  <= IDLE;
            busy <= 1'b0;
          end else if (upd_valid) begin
            network_state    <= nxt;
            iteration_number <= cnt_next;
            if (res != RES_NONE) begin
              fsm  <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
            case (res)
              RES_STEADY: begin
                steady_state <= 1'b1;
                cycle_len    <= CL_W'(1);
              end
              RES_CYCLE: begin
                cycle_detected <= 1'b1;
                cycle_len      <= match_idx + CL_W'(1);
              end
              RES_TIMEOUT: timeout <= 1'b1;
              default: ;
            endcase
          end
        end
        DONE: begin
          done <= 1'b0;
          fsm  <= IDLE;
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boolnet_attractor_sim.sv
// Directed bench for boolnet_attractor_sim with a behavioural update datapath.
module tb_boolnet_attractor_sim;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] initial_state;
  logic [9:0] max_iter;
  logic       ld_inhibitor;
  logic [2:0] sel_inhibitor;
  logic       clr_inhibitor;
  logic       upd_req;
  logic [7:0] upd_state;
  logic       upd_valid;
  logic [7:0] upd_next;
  logic [7:0] network_state;
  logic       busy;
  logic       done;
  logic       steady_state;
  logic       cycle_detected;
  logic       timeout;
  logic [2:0] cycle_len;
  logic [9:0] iteration_number;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ok;

  always #5 clk = ~clk;

  boolnet_attractor_sim #(.STATE_W(8), .HIST_DEPTH(4), .ITER_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .initial_state(initial_state), .max_iter(max_iter),
    .ld_inhibitor(ld_inhibitor), .sel_inhibitor(sel_inhibitor), .clr_inhibitor(clr_inhibitor),
    .upd_req(upd_req), .upd_state(upd_state), .upd_valid(upd_valid), .upd_next(upd_next),
    .network_state(network_state), .busy(busy), .done(done),
    .steady_state(steady_state), .cycle_detected(cycle_detected), .timeout(timeout),
    .cycle_len(cycle_len), .iteration_number(iteration_number)
  );

  // 0 identity, 1 rotl2, 2 increment, 3 rotl1, 4 set bit 0
  function automatic logic [7:0] model(input int mode, input logic [7:0] s);
    case (mode)
      1: return {s[5:0], s[7:6]};
      2: return s + 8'd1;
      3: return {s[6:0], s[7]};
      4: return s | 8'h01;
      default: return s;
    endcase
  endfunction

  // Runs until done is seen (ok=1) or the cycle budget expires; returns in the done cycle.
  task automatic run_model(input logic [7:0] init, input logic [9:0] mi,
                           input int mode, input int dly);
    int wcnt;
    @(posedge clk); #1;
    initial_state = init;
    max_iter      = mi;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok    = 0;
    wcnt  = 0;
    for (int c = 0; c < 300; c++) begin
      if (busy) begin
        upd_next  = model(mode, network_state);
        upd_valid = (wcnt >= dly);
        wcnt      = upd_valid ? 0 : wcnt + 1;
      end else begin
        upd_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        ok = 1;
        break;
      end
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({busy, done, upd_req, steady_state, cycle_detected, timeout, cycle_len,
         iteration_number, upd_state, network_state} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b req=%b st=%h iter=%0d",
               busy, done, upd_req, network_state, iteration_number);
    else pass_cnt++;
  endtask

  task automatic test_fixed_point();
    run_model(8'h3C, 10'd0, 0, 0);
    total_cnt++; if (ok !== 1) $display("FAIL fp_done: got %0d want 1", ok); else pass_cnt++;
    total_cnt++; if (steady_state !== 1'b1) $display("FAIL fp_steady: got %b want 1", steady_state); else pass_cnt++;
    total_cnt++; if (cycle_len !== 3'd1) $display("FAIL fp_len: got %0d want 1", cycle_len); else pass_cnt++;
    total_cnt++; if (iteration_number !== 10'd1) $display("FAIL fp_iter: got %0d want 1", iteration_number); else pass_cnt++;
    total_cnt++; if (network_state !== 8'h3C) $display("FAIL fp_state: got %h want 3c", network_state); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL fp_busy: got %b want 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL fp_done_pulse: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_attractor4();
    run_model(8'h01, 10'd0, 1, 0);
    total_cnt++; if (ok !== 1) $display("FAIL a4_done: got %0d want 1", ok); else pass_cnt++;
    total_cnt++; if ({cycle_detected, steady_state} !== 2'b10) $display("FAIL a4_flags: got %b want 10", {cycle_detected, steady_state}); else pass_cnt++;
    total_cnt++; if (cycle_len !== 3'd4) $display("FAIL a4_len: got %0d want 4", cycle_len); else pass_cnt++;
    total_cnt++; if (iteration_number !== 10'd4) $display("FAIL a4_iter: got %0d want 4", iteration_number); else pass_cnt++;
    total_cnt++; if (network_state !== 8'h01) $display("FAIL a4_state: got %h want 01", network_state); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    run_model(8'h00, 10'd10, 2, 0);
    total_cnt++; if (ok !== 1) $display("FAIL to_done: got %0d want 1", ok); else pass_cnt++;
    total_cnt++; if ({timeout, cycle_detected, steady_state} !== 3'b100) $display("FAIL to_flags: got %b want 100", {timeout, cycle_detected, steady_state}); else pass_cnt++;
    total_cnt++; if (iteration_number !== 10'd10) $display("FAIL to_iter: got %0d want 10", iteration_number); else pass_cnt++;
    total_cnt++; if (network_state !== 8'h0A) $display("FAIL to_state: got %h want 0a", network_state); else pass_cnt++;
    @(posedge clk); #1;
    run_model(8'h01, 10'd10, 3, 0);
    total_cnt++; if ({timeout, cycle_detected} !== 2'b10) $display("FAIL to_rot_flags: got %b want 10", {timeout, cycle_detected}); else pass_cnt++;
    total_cnt++; if (network_state !== 8'h04) $display("FAIL to_rot_state: got %h want 04", network_state); else pass_cnt++;
    total_cnt++; if (iteration_number !== 10'd10) $display("FAIL to_rot_iter: got %0d want 10", iteration_number); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_inhibitor();
    ld_inhibitor = 1'b1; sel_inhibitor = 3'd0;
    @(posedge clk); #1;
    ld_inhibitor = 1'b0;
    run_model(8'hFF, 10'd0, 4, 0);
    total_cnt++; if (network_state !== 8'hFE) $display("FAIL inh_state: got %h want fe", network_state); else pass_cnt++;
    total_cnt++; if ({steady_state, iteration_number} !== {1'b1, 10'd1}) $display("FAIL inh_steady: got %b/%0d want 1/1", steady_state, iteration_number); else pass_cnt++;
    @(posedge clk); #1;
    ld_inhibitor = 1'b1; clr_inhibitor = 1'b1; sel_inhibitor = 3'd5;
    @(posedge clk); #1;
    ld_inhibitor = 1'b0; clr_inhibitor = 1'b0;
    run_model(8'hFF, 10'd0, 0, 0);
    total_cnt++; if (network_state !== 8'hFF) $display("FAIL inh_clr_wins: got %h want ff", network_state); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_handshake();
    @(posedge clk); #1;
    initial_state = 8'h05; max_iter = 10'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++; if ({busy, upd_req, network_state} !== {2'b11, 8'h05}) $display("FAIL hs_start: got %b%b/%h want 11/05", busy, upd_req, network_state); else pass_cnt++;
    for (int a = 1; a <= 2; a++) begin
      for (int w = 0; w < 3; w++) begin
        upd_valid = 1'b0;
        upd_next  = 8'hA5;
        @(posedge clk); #1;
        total_cnt++;
        if ({upd_req, upd_state, iteration_number} !== {1'b1, 8'(5 + a - 1), 10'(a - 1)})
          $display("FAIL hs_wait: got req=%b st=%h it=%0d want 1/%h/%0d", upd_req, upd_state, iteration_number, 8'(5 + a - 1), a - 1);
        else pass_cnt++;
      end
      upd_next  = model(2, network_state);
      upd_valid = 1'b1;
      @(posedge clk); #1;
      upd_valid = 1'b0;
      total_cnt++;
      if ({iteration_number, network_state} !== {10'(a), 8'(5 + a)})
        $display("FAIL hs_accept: got it=%0d st=%h want %0d/%h", iteration_number, network_state, a, 8'(5 + a));
      else pass_cnt++;
    end
    total_cnt++; if ({done, timeout, busy} !== 3'b110) $display("FAIL hs_end: got %b want 110", {done, timeout, busy}); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    initial_state = 8'hFF; max_iter = 10'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ld_inhibitor = 1'b1; sel_inhibitor = 3'd1;
    @(posedge clk); #1;
    ld_inhibitor = 1'b0;
    total_cnt++; if ({busy, network_state} !== {1'b1, 8'hFF}) $display("FAIL ab_wait: got %b/%h want 1/ff", busy, network_state); else pass_cnt++;
    abort = 1'b1; upd_valid = 1'b1; upd_next = 8'h12;
    @(posedge clk); #1;
    abort = 1'b0; upd_valid = 1'b0;
    total_cnt++;
    if ({busy, done, steady_state, cycle_detected, timeout, network_state, iteration_number} !== {5'b0, 8'hFF, 10'd0})
      $display("FAIL ab_state: got b=%b d=%b flags=%b st=%h it=%0d want 0/0/000/ff/0", busy, done,
               {steady_state, cycle_detected, timeout}, network_state, iteration_number);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL ab_no_done: got %b want 0", done); else pass_cnt++;
    run_model(8'hFF, 10'd0, 0, 0);
    total_cnt++; if (network_state !== 8'hFF) $display("FAIL ab_mask_frozen: got %h want ff", network_state); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    ld_inhibitor = 1'b1; sel_inhibitor = 3'd2;
    @(posedge clk); #1;
    ld_inhibitor = 1'b0;
    initial_state = 8'hFF; max_iter = 10'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++; if ({busy, network_state} !== {1'b1, 8'hFB}) $display("FAIL ar_run: got %b/%h want 1/fb", busy, network_state); else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, upd_req, steady_state, cycle_detected, timeout, cycle_len,
         iteration_number, upd_state, network_state} !== '0)
      $display("FAIL ar_clear: got busy=%b req=%b st=%h it=%0d want all 0", busy, upd_req, network_state, iteration_number);
    else pass_cnt++;
    #2 rst = 1'b0;
    run_model(8'hFF, 10'd0, 0, 0);
    total_cnt++;
    if ({ok[0], steady_state, network_state, iteration_number} !== {2'b11, 8'hFF, 10'd1})
      $display("FAIL ar_rerun: got ok=%0d s=%b st=%h it=%0d want 1/1/ff/1", ok, steady_state, network_state, iteration_number);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    initial_state = '0; max_iter = '0;
    ld_inhibitor = 1'b0; sel_inhibitor = '0; clr_inhibitor = 1'b0;
    upd_valid = 1'b0; upd_next = '0;
    #2;
    test_reset();
    #10 rst = 1'b0;
    test_fixed_point();
    test_attractor4();
    test_timeout();
    test_inhibitor();
    test_handshake();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/boolnet_attractor_sim.md
# boolnet_attractor_sim

Parametrised Boolean-network simulation controller, the next generation of the network-simulation top level. It loads an initial state under an inhibitor mask and iterates the network through an external update datapath using a req/valid handshake. It detects steady states and short attractor cycles up to `HIST_DEPTH`, and stops on an iteration limit or an abort. Results are held for the host until the next run.

## Interface
Parameters:
- `STATE_W`, 16: number of network elements.
- `HIST_DEPTH`, 4: stored past states, which is the maximum detectable cycle length. Must be ≥1.
- `ITER_W`, 10: iteration counter width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run. Sampled in IDLE only.
- `abort` in 1: stop the current run. Effective in RUN only.
- `initial_state` in `STATE_W`: starting state, sampled with `start`.
- `max_iter` in `ITER_W`: iteration limit, sampled with `start`. 0 means unlimited.
- `ld_inhibitor` in 1: set one mask bit.
- `sel_inhibitor` in `$clog2(STATE_W)`: index of the mask bit to set.
- `clr_inhibitor` in 1: clear the whole mask.
- `upd_req` out 1: update request to the datapath.
- `upd_state` out `STATE_W`: current state presented to the datapath. Equals `network_state`.
- `upd_valid` in 1: the datapath's next state is valid.
- `upd_next` in `STATE_W`: the datapath's next state.
- `network_state` out `STATE_W`: current state.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle completion pulse.
- `steady_state`, `cycle_detected`, `timeout` out 1: result flags.
- `cycle_len` out `$clog2(HIST_DEPTH+1)`: detected attractor length.
- `iteration_number` out `ITER_W`: number of updates accepted.

## Operation
- **Reset** (asynchronous): FSM goes to IDLE. Every output, the mask, the history registers and the history valid bits are 0.
- **Inhibitor mask:**
  - `ld_inhibitor` sets `mask[sel_inhibitor]`. An index ≥ `STATE_W` is ignored.
  - `clr_inhibitor` clears the mask and wins when asserted together with `ld_inhibitor`.
  - Mask writes are ignored while `busy` is high.
- **IDLE → RUN** on `start`:
  - `network_state` ← `initial_state & ~mask`.
  - `hist[0]` ← that same value; all other history valid bits cleared.
  - `iteration_number` ← 0; result flags and `cycle_len` cleared; `max_iter` latched.
- **RUN:**
  - `upd_req` = 1 and `upd_state` = `network_state`.
  - An update is accepted in any cycle with `upd_valid` = 1. Let `nxt` = `upd_next & ~mask`.
  - On acceptance: the history shifts (`hist[k+1]` ← `hist[k]`, entries beyond `HIST_DEPTH` are dropped), `hist[0]` ← `nxt`, `network_state` ← `nxt`, `iteration_number` += 1.
- **Termination check** (same cycle as acceptance):
  - `nxt` is compared against valid `hist[j]` for j = 0..`HIST_DEPTH`−1, before the shift. The lowest matching j wins.
  - j = 0: `steady_state` = 1, `cycle_len` = 1.
  - j ≥ 1: `cycle_detected` = 1, `cycle_len` = j+1.
  - No match, with `max_iter` ≠ 0 and the new count equal to `max_iter`: `timeout` = 1.
  - No match, with `max_iter` = 0 and the new count all-ones: `timeout` = 1.
  - A match takes precedence over timeout on the same update.
  - Any of these conditions moves the FSM to DONE.
- **Abort:** `abort` in RUN goes to IDLE on the next edge, even if `upd_valid` is also high (that update is discarded). No `done`; flags stay 0; `network_state` keeps its last value.
- **DONE** (one cycle): `done` = 1, `busy` = 0, then IDLE. `start` during DONE is ignored.
- Flags, `cycle_len`, `network_state` and `iteration_number` hold until the next accepted `start`.
- `upd_valid` outside RUN is ignored.

## Timing
- `start` at edge N: `busy` and `upd_req` are high from cycle N+1.
- `upd_valid` may be asserted in the same cycle `upd_req` rises. The datapath may be combinational, giving 1 cycle per iteration.
- `upd_req` stays high and `network_state` stays stable until acceptance or abort. Any number of wait cycles is allowed.
- Acceptance at edge M: new state, count and flags are visible in cycle M+1, together with `done` = 1. `busy` falls in the same cycle, and the FSM is back in IDLE at M+2.
- `rst` asserted mid-run clears everything immediately, without waiting for a clock edge.

## Structure
- **Package `boolnet_pkg`:**
  - FSM enum `{IDLE, RUN, DONE}`.
  - Result-kind enum.
  - Localparam helper for the `cycle_len` width, `$clog2(HIST_DEPTH+1)`.
- **Sub-module `state_history`:**
  - `HIST_DEPTH` × `STATE_W` shift register with valid bits.
  - Parallel equality compare against `nxt`.
  - Lowest-index priority encoder.
  - Outputs `match` and `match_idx`.
- The top holds the FSM, the mask, the counter and the result registers.

## Test plan
The bench uses `STATE_W`=8, `HIST_DEPTH`=4 and `ITER_W`=10. The update model is a behavioural function with configurable `upd_valid` delay.
- **Fixed point:** model next = state, initial 8'h3C, `max_iter` = 0. Expect `steady_state` = 1, `cycle_len` = 1, `iteration_number` = 1, `network_state` = 8'h3C, `done` high for exactly one cycle.
- **4-cycle attractor:** model rotate-left by 2, initial 8'h01. States run 04, 10, 40, 01. Expect `cycle_detected` = 1, `cycle_len` = 4, `iteration_number` = 4, `network_state` = 8'h01.
- **Timeout:** model next = state + 1, initial 8'h00, `max_iter` = 10. Expect `timeout` = 1, `iteration_number` = 10, `network_state` = 8'h0A. Repeat with rotate-left by 1 (period 8 > depth): timeout, no cycle flag.
- **Inhibitor:**
  - `ld_inhibitor`, `sel` = 0, then initial 8'hFF: `network_state` = 8'hFE. Model next = state | 1: steady at iteration 1, state 8'hFE.
  - `ld` and `clr` in the same cycle: mask = 0.
  - `ld` while busy: mask unchanged.
- **Handshake and abort:**
  - `upd_valid` delayed 3 cycles: `upd_req` held, state stable, one increment per acceptance.
  - `abort` during a wait: `busy` = 0 next cycle, no `done`, flags 0.
- **Async reset:** assert `rst` mid-RUN between clock edges. Expect all outputs and the mask at 0 immediately. After release, `start` runs normally.
